// File: rtl/wdi_kick_gen.sv
// -----------------------------------------------------------------------------
// wdi_kick_gen
//   Multi-channel watchdog-kick (WDI) generator with firmware heartbeat
//   supervision. Each channel toggles an external supervisor's WDI pin with a
//   programmable high/low pattern timed in PULSE_100US ticks. If a channel's
//   ALIVE heartbeat goes missing for ALIVE_TICKS ticks, the channel stops
//   kicking so the external supervisor resets the board.
//
// Configuration macro:
//   WDI_STARVE_LATCH_EN  defined   : STARVE is sticky; only KICK_EN=0 or
//                                    OPB_RST leave it.
//                        undefined : ALIVE while starved returns the channel
//                                    to IDLE, and the next tick restarts
//                                    kicking.
//
// Ports:
//   OPB_CLK      in   1       system clock, posedge
//   OPB_RST      in   1       asynchronous, active-high reset
//   PULSE_100US  in   1       tick enable, one OPB_CLK cycle wide
//   KICK_EN      in   NUM_CH  per-channel enable (level)
//   ALIVE        in   NUM_CH  per-channel heartbeat strobe
//   WD_OUT       out  NUM_CH  registered WDI outputs
//   STARVED      out  NUM_CH  channel halted because ALIVE was missing
// -----------------------------------------------------------------------------
module wdi_kick_gen #(
   parameter int NUM_CH       = 2,
   parameter int CNT_W        = 8,
   parameter int HIGH_TICKS   = 1,
   parameter int PERIOD_TICKS = 10,
   parameter int ALIVE_TICKS  = 50
) (
   input  logic              OPB_CLK,
   input  logic              OPB_RST,
   input  logic              PULSE_100US,
   input  logic [NUM_CH-1:0] KICK_EN,
   input  logic [NUM_CH-1:0] ALIVE,
   output logic [NUM_CH-1:0] WD_OUT,
   output logic [NUM_CH-1:0] STARVED
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HIGH   = 2'd1,
      ST_LOW    = 2'd2,
      ST_STARVE = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] HIGH_LAST   = CNT_W'(HIGH_TICKS - 1);
   localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_TICKS - 1);
   localparam logic [CNT_W-1:0] ALIVE_LIMIT = CNT_W'(ALIVE_TICKS);
   localparam bit               SUPERVISE   = (ALIVE_TICKS != 0);

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch

      state_t             state;
      logic [CNT_W-1:0]   ph;
      logic [CNT_W-1:0]   alive;
      logic               wd;
      logic               starved;

      // Per-channel kick FSM. Outputs are computed alongside the next state so
      // they change on the same edge as the state register. The starve check
      // uses the registered alive count, so a heartbeat arriving together with
      // the tick that would have reached the limit keeps the channel alive.
      always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
         if (OPB_RST) begin
            state   <= ST_IDLE;
            ph      <= '0;
            alive   <= '0;
            wd      <= 1'b0;
            starved <= 1'b0;
         end else if (!KICK_EN[c]) begin
            state   <= ST_IDLE;
            ph      <= '0;
            alive   <= '0;
            wd      <= 1'b0;
            starved <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (PULSE_100US) begin
                     state <= ST_HIGH;
                     ph    <= '0;
                     wd    <= 1'b1;
                  end
               end

               ST_HIGH, ST_LOW: begin
                  if (SUPERVISE && (alive == ALIVE_LIMIT)) begin
                     state   <= ST_STARVE;
                     ph      <= '0;
                     wd      <= 1'b0;
                     starved <= 1'b1;
                  end else begin
                     if (ALIVE[c]) begin
                        alive <= '0;
                     end else if (PULSE_100US && (alive != CNT_MAX)) begin
                        alive <= alive + 1'b1;
                     end

                     if (PULSE_100US) begin
                        if ((state == ST_HIGH) && (ph == HIGH_LAST)) begin
                           state <= ST_LOW;
                           ph    <= ph + 1'b1;
                           wd    <= 1'b0;
                        end else if ((state == ST_LOW) && (ph == PERIOD_LAST)) begin
                           state <= ST_HIGH;
                           ph    <= '0;
                           wd    <= 1'b1;
                        end else begin
                           ph <= ph + 1'b1;
                        end
                     end
                  end
               end

               ST_STARVE: begin
`ifdef WDI_STARVE_LATCH_EN
                  // Sticky: heartbeats are ignored until KICK_EN drops.
                  state <= ST_STARVE;
`else
                  // A late heartbeat releases the channel; kicking restarts
                  // from the first phase on the next tick.
                  if (ALIVE[c]) begin
                     state   <= ST_IDLE;
                     alive   <= '0;
                     starved <= 1'b0;
                  end
`endif
               end

               default: begin
                  state   <= ST_IDLE;
                  ph      <= '0;
                  alive   <= '0;
                  wd      <= 1'b0;
                  starved <= 1'b0;
               end
            endcase
         end
      end

      assign WD_OUT[c]  = wd;
      assign STARVED[c] = starved;
   end

endmodule

// File: tb/tb_wdi_kick_gen.sv
// -----------------------------------------------------------------------------
// tb_wdi_kick_gen
//   Directed self-checking bench for wdi_kick_gen. One instance runs the
//   default parameters (1 high / 9 low, starve after 50 ticks); a second runs
//   HIGH_TICKS=3, PERIOD_TICKS=8 with supervision disabled.
// -----------------------------------------------------------------------------
module tb_wdi_kick_gen;

   logic       clock;
   logic       rst;
   logic       pulse;
   logic [1:0] kick;
   logic [1:0] alive;
   logic [1:0] wd;
   logic [1:0] starved;
   logic [1:0] kick38;
   logic [1:0] alive38;
   logic [1:0] wd38;
   logic [1:0] starved38;

   int compared;
   int mismatched;

   wdi_kick_gen dut (
      .OPB_CLK     (clock),
      .OPB_RST     (rst),
      .PULSE_100US (pulse),
      .KICK_EN     (kick),
      .ALIVE       (alive),
      .WD_OUT      (wd),
      .STARVED     (starved)
   );

   wdi_kick_gen #(
      .NUM_CH       (2),
      .CNT_W        (8),
      .HIGH_TICKS   (3),
      .PERIOD_TICKS (8),
      .ALIVE_TICKS  (0)
   ) dut38 (
      .OPB_CLK     (clock),
      .OPB_RST     (rst),
      .PULSE_100US (pulse),
      .KICK_EN     (kick38),
      .ALIVE       (alive38),
      .WD_OUT      (wd38),
      .STARVED     (starved38)
   );

   // 10 time-unit clock
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Drive one clock cycle of inputs, then sample 1 unit after the edge.
   task automatic applyStimulus(input logic p, input logic [1:0] al);
      pulse = p;
      alive = al;
      @(posedge clock);
      #1;
      pulse = 1'b0;
      alive = 2'b00;
   endtask

   task automatic checkOutput(input string tag, input logic [1:0] observed,
                              input logic [1:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
      end
   endtask

   initial begin
      logic [1:0] exp_wd;
      compared   = 0;
      mismatched = 0;
      rst     = 1'b1;
      pulse   = 1'b0;
      kick    = 2'b00;
      alive   = 2'b00;
      kick38  = 2'b00;
      alive38 = 2'b00;

      // Reset state
      #12;
      checkOutput("reset_wd", wd, 2'b00);
      checkOutput("reset_starved", starved, 2'b00);
      rst  = 1'b0;
      kick = 2'b11;

      // Enabled but no tick yet: stays idle
      applyStimulus(1'b0, 2'b00);
      checkOutput("idle_no_tick", wd, 2'b00);

      // First tick: WD rises one clock later
      applyStimulus(1'b1, 2'b00);
      checkOutput("first_rise", wd, 2'b11);

      // Three periods of 1 high / 9 low, ALIVE on every 10th tick
      for (int p = 0; p < 3; p++) begin
         for (int t = 1; t <= 10; t++) begin
            exp_wd = (t == 10) ? 2'b11 : 2'b00;
            applyStimulus(1'b1, (t == 10) ? 2'b11 : 2'b00);
            checkOutput("s1_tick", wd, exp_wd);
            applyStimulus(1'b0, 2'b00);
            checkOutput("s1_hold", wd, exp_wd);
         end
      end
      checkOutput("s1_starved", starved, 2'b00);

      // ALIVE coincident with the tick that would make alive=50
      for (int k = 1; k <= 49; k++) applyStimulus(1'b1, 2'b00);
      checkOutput("s4_pre_wd", wd, 2'b00);
      checkOutput("s4_pre_starved", starved, 2'b00);
      applyStimulus(1'b1, 2'b11);
      checkOutput("s4_wd", wd, 2'b11);
      applyStimulus(1'b0, 2'b00);
      checkOutput("s4_no_starve", starved, 2'b00);
      checkOutput("s4_wd_hold", wd, 2'b11);

      // ch0 loses its heartbeat, ch1 keeps it
      for (int k = 1; k <= 50; k++)
         applyStimulus(1'b1, ((k % 10) == 0) ? 2'b10 : 2'b00);
      checkOutput("s3_tick50_wd", wd, 2'b11);
      checkOutput("s3_tick50_starved", starved, 2'b00);
      applyStimulus(1'b0, 2'b00);
      checkOutput("s3_starve_wd", wd, 2'b10);
      checkOutput("s3_starve_flag", starved, 2'b01);
      applyStimulus(1'b1, 2'b00);
      checkOutput("s6_ch1_runs", wd, 2'b00);
      checkOutput("s6_ch0_still_starved", starved, 2'b01);

      // Heartbeat returns on ch0
      applyStimulus(1'b0, 2'b01);
`ifdef WDI_STARVE_LATCH_EN
      checkOutput("s3_alive_in_starve", starved, 2'b01);
`else
      checkOutput("s3_alive_in_starve", starved, 2'b00);
`endif
      applyStimulus(1'b1, 2'b00);
`ifdef WDI_STARVE_LATCH_EN
      checkOutput("s3_after_alive_wd", wd, 2'b00);
      checkOutput("s3_after_alive_starved", starved, 2'b01);
`else
      checkOutput("s3_after_alive_wd", wd, 2'b01);
      checkOutput("s3_after_alive_starved", starved, 2'b00);
`endif

      // KICK_EN drop on ch0, then re-enable
      kick = 2'b10;
      applyStimulus(1'b0, 2'b00);
      checkOutput("s5_disable_wd", wd, 2'b00);
      checkOutput("s5_disable_starved", starved, 2'b00);
      kick = 2'b11;
      applyStimulus(1'b0, 2'b00);
      checkOutput("s5_reenable_wait", wd, 2'b00);
      applyStimulus(1'b1, 2'b00);
      checkOutput("s5_reenable_rise", wd, 2'b01);

      // Asynchronous reset while ch0 is high
      #2;
      rst = 1'b1;
      #1;
      checkOutput("s6_async_rst_wd", wd, 2'b00);
      checkOutput("s6_async_rst_starved", starved, 2'b00);
      rst = 1'b0;
      applyStimulus(1'b0, 2'b00);
      checkOutput("s6_post_rst_idle", wd, 2'b00);

      // 3 high / 8 period, supervision off, 20 periods
      kick   = 2'b00;
      kick38 = 2'b11;
      applyStimulus(1'b1, 2'b00);
      checkOutput("s2_first_rise", wd38, 2'b11);
      for (int k = 1; k <= 160; k++) begin
         applyStimulus(1'b1, 2'b00);
         checkOutput("s2_pattern", wd38, ((k % 8) < 3) ? 2'b11 : 2'b00);
      end
      checkOutput("s2_no_supervision", starved38, 2'b00);
      checkOutput("s2_main_disabled", wd, 2'b00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
